// File: rtl/time_keeper_pkg.sv
// -----------------------------------------------------------------------------
// time_keeper_pkg
// Shared definitions for the HH:MM:SS time keeper:
//   - set-mode FSM state encodings (RUN / SET_HR / SET_MIN)
//   - BCD digit limits for seconds, minutes and hours
//   - helpers for converting the internal 24 h hour count to a 12 h display
// No ports (package).
// -----------------------------------------------------------------------------
package time_keeper_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX       = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX  = 4'd5;
    localparam int         HOUR_MAX      = 23;
    localparam logic [3:0] HOUR_TENS_TOP = 4'(HOUR_MAX / 10);
    localparam logic [3:0] HOUR_ONES_TOP = 4'(HOUR_MAX % 10);

    // BCD hour digits -> binary 0..23
    function automatic logic [4:0] hour_bin(input logic [3:0] tens, input logic [3:0] ones);
        return 5'((tens * 10) + ones);
    endfunction

    // Binary 24 h hour -> 12 h BCD display {tens, ones}: 0 -> 12, 13..23 -> 1..11
    function automatic logic [7:0] hour12_bcd(input logic [4:0] h24);
        logic [4:0] h12;
        h12 = h24;
        if (h24 == 5'd0) begin
            h12 = 5'd12;
        end else if (h24 > 5'd12) begin
            h12 = h24 - 5'd12;
        end
        if (h12 >= 5'd10) begin
            return {4'd1, 4'(h12 - 5'd10)};
        end
        return {4'd0, 4'(h12)};
    endfunction

endpackage

// File: rtl/time_keeper_btn_debounce.sv
// -----------------------------------------------------------------------------
// time_keeper_btn_debounce
// Push-button conditioner: 2-FF synchroniser, stable-level counter and a
// one-cycle press pulse on an accepted 0->1 level change. Holding the button
// gives no repeats; a new level is accepted only after DEB_CYCLES consecutive
// synchronised samples that differ from the current accepted level.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset (level 0, no pulse)
//   btn_i    in   raw button, active-high, asynchronous to clk
//   press_o  out  one-cycle registered press pulse
// -----------------------------------------------------------------------------
module time_keeper_btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any sample equal to the accepted level restarts the stability run.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
// Real-time HH:MM:SS counter producing six BCD digits for a multiplexed
// 7-segment driver. A prescaler divides clk to a 1 Hz tick that advances
// cascaded BCD counters (23:59:59 -> 00:00:00). Two debounced buttons drive a
// set-mode FSM: RUN -> SET_HR -> SET_MIN -> RUN, with inc editing the field.
// Optional feature macro: HOUR12_EN
//   defined   : hour digits shown in 12 h form, pm = 1 for hours 12..23
//   undefined : 24 h display, pm tied to 0
// Ports:
//   clk        in   system clock (rising edge)
//   rst        in   asynchronous active-low reset
//   btn_mode   in   raw mode button, active-high
//   btn_inc    in   raw increment button, active-high
//   number0..5 out  BCD digits: sec ones/tens, min ones/tens, hour ones/tens
//   sec_tick   out  one-cycle pulse when seconds advance in RUN
//   set_mode   out  FSM state (0 RUN, 1 SET_HR, 2 SET_MIN)
//   pm         out  PM indicator
// -----------------------------------------------------------------------------
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] number0,
    output logic [3:0] number1,
    output logic [3:0] number2,
    output logic [3:0] number3,
    output logic [3:0] number4,
    output logic [3:0] number5,
    output logic       sec_tick,
    output logic [1:0] set_mode,
    output logic       pm
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    logic mode_press;
    logic inc_press;

    time_keeper_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_mode),
        .press_o (mode_press)
    );

    time_keeper_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_inc),
        .press_o (inc_press)
    );

    state_e        state_q;
    logic [PW-1:0] pre_q;
    logic [3:0]    sec_o_q, sec_t_q, min_o_q, min_t_q, hr_o_q, hr_t_q;
    logic          sec_tick_q;

    logic          tick;
    logic          sec_wrap, min_wrap;
    logic [3:0]    sec_o_inc, sec_t_inc, min_o_inc, min_t_inc, hr_o_inc, hr_t_inc;

    assign tick = (state_q == ST_RUN) && (pre_q == PRE_MAX);

    // Per-field "+1" values; the sequential block decides which ones to apply.
    always_comb begin
        sec_wrap  = (sec_t_q == SEC_TENS_MAX) && (sec_o_q == BCD_MAX);
        min_wrap  = (min_t_q == MIN_TENS_MAX) && (min_o_q == BCD_MAX);
        sec_o_inc = sec_o_q + 4'd1;
        sec_t_inc = sec_t_q;
        min_o_inc = min_o_q + 4'd1;
        min_t_inc = min_t_q;
        hr_o_inc  = hr_o_q + 4'd1;
        hr_t_inc  = hr_t_q;
        if (sec_o_q == BCD_MAX) begin
            sec_o_inc = 4'd0;
            sec_t_inc = sec_wrap ? 4'd0 : sec_t_q + 4'd1;
        end
        if (min_o_q == BCD_MAX) begin
            min_o_inc = 4'd0;
            min_t_inc = min_wrap ? 4'd0 : min_t_q + 4'd1;
        end
        if ((hr_t_q == HOUR_TENS_TOP) && (hr_o_q == HOUR_ONES_TOP)) begin
            hr_o_inc = 4'd0;
            hr_t_inc = 4'd0;
        end else if (hr_o_q == BCD_MAX) begin
            hr_o_inc = 4'd0;
            hr_t_inc = hr_t_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            pre_q      <= '0;
            sec_o_q    <= 4'd0;
            sec_t_q    <= 4'd0;
            min_o_q    <= 4'd0;
            min_t_q    <= 4'd0;
            hr_o_q     <= 4'd0;
            hr_t_q     <= 4'd0;
            sec_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    // A mode press discards a coincident tick; prescaler parks at 0.
                    if (mode_press) begin
                        state_q <= ST_SET_HR;
                        pre_q   <= '0;
                    end else if (tick) begin
                        pre_q      <= '0;
                        sec_tick_q <= 1'b1;
                        sec_o_q    <= sec_o_inc;
                        sec_t_q    <= sec_t_inc;
                        if (sec_wrap) begin
                            min_o_q <= min_o_inc;
                            min_t_q <= min_t_inc;
                            if (min_wrap) begin
                                hr_o_q <= hr_o_inc;
                                hr_t_q <= hr_t_inc;
                            end
                        end
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end
                ST_SET_HR: begin
                    if (mode_press) begin
                        state_q <= ST_SET_MIN;
                    end else if (inc_press) begin
                        hr_o_q <= hr_o_inc;
                        hr_t_q <= hr_t_inc;
                    end
                end
                ST_SET_MIN: begin
                    if (mode_press) begin
                        state_q <= ST_RUN;
                        sec_o_q <= 4'd0;
                        sec_t_q <= 4'd0;
                        pre_q   <= '0;
                    end else if (inc_press) begin
                        min_o_q <= min_o_inc;
                        min_t_q <= min_t_inc;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    pre_q   <= '0;
                end
            endcase
        end
    end

    assign number0  = sec_o_q;
    assign number1  = sec_t_q;
    assign number2  = min_o_q;
    assign number3  = min_t_q;
    assign sec_tick = sec_tick_q;
    assign set_mode = state_q;

`ifdef HOUR12_EN
    logic [4:0] hr_bin;
    logic [7:0] hr12;
    assign hr_bin  = hour_bin(hr_t_q, hr_o_q);
    assign hr12    = hour12_bcd(hr_bin);
    assign number5 = hr12[7:4];
    assign number4 = hr12[3:0];
    assign pm      = (hr_bin >= 5'd12);
`else
    assign number5 = hr_t_q;
    assign number4 = hr_o_q;
    assign pm      = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] number0, number1, number2, number3, number4, number5;
    logic       sec_tick;
    logic [1:0] set_mode;
    logic       pm;

    int n_cmp = 0;
    int n_err = 0;

    time_keeper #(.CLK_HZ(4), .DEB_CYCLES(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .number0  (number0),
        .number1  (number1),
        .number2  (number2),
        .number3  (number3),
        .number4  (number4),
        .number5  (number5),
        .sec_tick (sec_tick),
        .set_mode (set_mode),
        .pm       (pm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press and release with enough hold time for the debouncer to accept both levels.
    task automatic press(input bit is_inc);
        if (is_inc) btn_inc = 1'b1; else btn_mode = 1'b1;
        step(7);
        btn_inc  = 1'b0;
        btn_mode = 1'b0;
        step(7);
    endtask

    function automatic logic [7:0] hr_disp(input int h);
        int d;
        d = h;
`ifdef HOUR12_EN
        if (h == 0) d = 12;
        else if (h > 12) d = h - 12;
`endif
        return {4'(d / 10), 4'(d % 10)};
    endfunction

    function automatic logic [23:0] exp_tm(input int h, input int m, input int s);
        return {hr_disp(h), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [23:0] tm();
        return {number5, number4, number3, number2, number1, number0};
    endfunction

    function automatic logic legal();
        return (number0 <= 4'd9) && (number1 <= 4'd5) && (number2 <= 4'd9) &&
               (number3 <= 4'd5) && (number4 <= 4'd9) && (number5 <= 4'd2) &&
               !((number5 == 4'd2) && (number4 > 4'd3));
    endfunction

    initial begin
        int ticks;

        // Reset state
        step(5);
        check("rst_time", tm(), 24'h000000);
        check("rst_tick", sec_tick, 1'b0);
        check("rst_mode", set_mode, 2'd0);
        check("rst_pm", pm, 1'b0);
        rst = 1'b1;

        // Free-running seconds: tick every 4 cycles, 10 ticks -> 00:00:10
        ticks = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (sec_tick) ticks++;
            if (i == 3)  check("tick_c3", sec_tick, 1'b0);
            if (i == 4)  check("tick_c4", sec_tick, 1'b1);
            if (i == 5)  check("tick_c5", sec_tick, 1'b0);
            if (i == 39) check("run_9s", tm(), exp_tm(0, 0, 9));
            if (i == 40) check("run_10s", tm(), exp_tm(0, 0, 10));
        end
        check("tick_count", ticks, 10);

        // Set mode: one more tick lands before the mode press is accepted
        press(1'b0);
        check("set_hr_mode", set_mode, 2'd1);
        check("set_hr_time", tm(), exp_tm(0, 0, 11));
        step(20);
        check("frozen_time", tm(), exp_tm(0, 0, 11));
        for (int i = 0; i < 25; i++) begin
            press(1'b1);
            check("hr_inc", {number5, number4}, hr_disp((i + 1) % 24));
        end
        check("hr_only", tm(), exp_tm(1, 0, 11));
        press(1'b0);
        check("set_min_mode", set_mode, 2'd2);
        for (int i = 0; i < 60; i++) begin
            press(1'b1);
            check("min_inc", {number3, number2}, 8'(((i + 1) % 60 / 10) * 16 + (i + 1) % 10));
        end
        check("min_only", tm(), exp_tm(1, 0, 11));
        btn_mode = 1'b1;
        step(6);
        check("exit_mode", set_mode, 2'd0);
        check("exit_time", tm(), exp_tm(1, 0, 0));
        check("exit_tick0", sec_tick, 1'b0);
        btn_mode = 1'b0;
        step(3);
        check("exit_tick3", sec_tick, 1'b0);
        step(1);
        check("exit_tick4", sec_tick, 1'b1);
        check("exit_first", tm(), exp_tm(1, 0, 1));

        // Preload 23:59:xx via set mode, then roll over midnight
        press(1'b0);
        for (int i = 0; i < 22; i++) press(1'b1);
        press(1'b0);
        for (int i = 0; i < 59; i++) press(1'b1);
        check("preload_hm", {number5, number4, number3, number2}, {hr_disp(23), 8'h59});
        btn_mode = 1'b1;
        step(6);
        check("preload_exit", tm(), exp_tm(23, 59, 0));
        btn_mode = 1'b0;
        step(232);
        check("at_235958", tm(), exp_tm(23, 59, 58));
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check("bcd_legal", legal(), 1'b1);
            if (i == 4) check("at_235959", tm(), exp_tm(23, 59, 59));
            if (i == 7) check("hold_235959", tm(), exp_tm(23, 59, 59));
            if (i == 8) check("wrap_000000", tm(), exp_tm(0, 0, 0));
            if (i == 8) check("wrap_tick", sec_tick, 1'b1);
        end

        // Bouncing inc button in SET_HR: exactly one press, 6 cycles after settling
        press(1'b0);
        check("bnc_mode", set_mode, 2'd1);
        check("bnc_hr0", {number5, number4}, hr_disp(0));
        for (int i = 0; i < 10; i++) begin
            btn_inc = (i % 2 == 0);
            step(1);
        end
        btn_inc = 1'b1;
        step(5);
        check("bnc_c5", {number5, number4}, hr_disp(0));
        step(1);
        check("bnc_c6", {number5, number4}, hr_disp(1));
        step(20);
        check("bnc_hold", {number5, number4}, hr_disp(1));
        btn_inc = 1'b0;
        step(10);
        check("bnc_release", {number5, number4}, hr_disp(1));

        // Mode press on a tick cycle: tick is discarded
        press(1'b0);
        btn_mode = 1'b1;
        step(6);
        check("coin_run", tm(), exp_tm(1, 0, 0));
        btn_mode = 1'b0;
        step(10);
        btn_mode = 1'b1;
        step(5);
        check("coin_pre_mode", set_mode, 2'd0);
        check("coin_pre_time", tm(), exp_tm(1, 0, 3));
        step(1);
        check("coin_mode", set_mode, 2'd1);
        check("coin_time", tm(), exp_tm(1, 0, 3));
        check("coin_tick", sec_tick, 1'b0);
        btn_mode = 1'b0;
        step(7);

        // Asynchronous reset during a SET_MIN edit
        press(1'b0);
        press(1'b1);
        check("edit_min", {number3, number2}, 8'h01);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_time", tm(), 24'h000000);
        check("async_mode", set_mode, 2'd0);
        @(negedge clk);
        rst = 1'b1;

        // inc in RUN is ignored
        press(1'b1);
        check("run_inc_mode", set_mode, 2'd0);
        check("run_inc_time", tm(), exp_tm(0, 0, 3));

        // Hour display / pm
`ifdef HOUR12_EN
        check("h00_disp", {number5, number4}, 8'h12);
        check("h00_pm", pm, 1'b0);
`else
        check("h00_disp", {number5, number4}, 8'h00);
        check("h00_pm", pm, 1'b0);
`endif
        press(1'b0);
        for (int i = 0; i < 13; i++) press(1'b1);
`ifdef HOUR12_EN
        check("h13_disp", {number5, number4}, 8'h01);
        check("h13_pm", pm, 1'b1);
`else
        check("h13_disp", {number5, number4}, 8'h13);
        check("h13_pm", pm, 1'b0);
`endif
        for (int i = 0; i < 23; i++) press(1'b1);
`ifdef HOUR12_EN
        check("h12_disp", {number5, number4}, 8'h12);
        check("h12_pm", pm, 1'b1);
`else
        check("h12_disp", {number5, number4}, 8'h12);
        check("h12_pm", pm, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
